// File: rtl/decompressor_pkg.sv
// Shared types and constants for the decompressor front end: unpacker FSM states,
// control-bit meanings and the item width handed to the decompressor core.
package decompressor_pkg;

  localparam int unsigned ITEM_WIDTH = 16;

  localparam logic CTRL_LITERAL = 1'b0;
  localparam logic CTRL_COPY    = 1'b1;

  typedef enum logic [2:0] {
    U_CTRL_LO,
    U_CTRL_HI,
    U_ITEM_B0,
    U_ITEM_B1,
    U_EMIT
  } unpack_state_e;

endpackage

// File: rtl/stream_unpacker.sv
// Splits a compressed byte stream into control-word-governed literal/copy items and
// presents them one at a time to the decompressor through a single output register.
module stream_unpacker
  import decompressor_pkg::*;
#(
  parameter int unsigned ITEMS_PER_GROUP = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [ITEM_WIDTH-1:0] data_out,
  output logic                  control_word_out,
  output logic                  out_data_valid,
  input  logic                  decompressor_busy,
  output logic                  protocol_error
);

  localparam logic [3:0] LAST_IDX = 4'(ITEMS_PER_GROUP - 1);

  unpack_state_e         state_q, state_d;
  logic [15:0]           ctrl_q, ctrl_d;
  logic [3:0]            count_q, count_d;
  logic [ITEM_WIDTH-1:0] data_q, data_d;
  logic                  kind_q, kind_d;
  logic                  last_q, last_d;
  logic                  perr_q, perr_d;
  logic                  accept;
  logic                  cur_bit;

  assign byte_ready       = (state_q != U_EMIT);
  assign out_data_valid   = (state_q == U_EMIT);
  assign data_out         = data_q;
  assign control_word_out = kind_q;
  assign protocol_error   = perr_q;

  assign accept  = byte_valid && byte_ready;
  assign cur_bit = ctrl_q[count_q];

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    count_d = count_q;
    data_d  = data_q;
    kind_d  = kind_q;
    last_d  = last_q;
    perr_d  = 1'b0;
    unique case (state_q)
      U_CTRL_LO: begin
        if (accept) begin
          if (byte_last) begin
            perr_d = 1'b1;
            ctrl_d = '0;
          end else begin
            ctrl_d[7:0] = byte_in;
            state_d     = U_CTRL_HI;
          end
        end
      end
      U_CTRL_HI: begin
        if (accept) begin
          count_d = '0;
          if (byte_last) begin
            perr_d  = 1'b1;
            ctrl_d  = '0;
            state_d = U_CTRL_LO;
          end else begin
            ctrl_d[15:8] = byte_in;
            state_d      = U_ITEM_B0;
          end
        end
      end
      U_ITEM_B0: begin
        if (accept) begin
          if (cur_bit == CTRL_LITERAL) begin
            data_d  = {8'h00, byte_in};
            kind_d  = CTRL_LITERAL;
            last_d  = byte_last;
            state_d = U_EMIT;
          end else if (byte_last) begin
            // Stream ended halfway through a copy: drop the group entirely.
            perr_d  = 1'b1;
            ctrl_d  = '0;
            count_d = '0;
            state_d = U_CTRL_LO;
          end else begin
            data_d[15:8] = byte_in;
            state_d      = U_ITEM_B1;
          end
        end
      end
      U_ITEM_B1: begin
        if (accept) begin
          data_d[7:0] = byte_in;
          kind_d      = CTRL_COPY;
          last_d      = byte_last;
          state_d     = U_EMIT;
        end
      end
      U_EMIT: begin
        if (!decompressor_busy) begin
          if (count_q == LAST_IDX || last_q) begin
            count_d = '0;
            state_d = U_CTRL_LO;
          end else begin
            count_d = count_q + 4'd1;
            state_d = U_ITEM_B0;
          end
        end
      end
      default: state_d = U_CTRL_LO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= U_CTRL_LO;
      ctrl_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      kind_q  <= 1'b0;
      last_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
      last_q  <= last_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench: a stream-parsing model predicts items and protocol errors for
// a 16-item and a 4-item unpacker; one negedge process scores every output transfer.
module tb_stream_unpacker;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid, byte_last, busy, sel;
  int          busy_mode;

  logic        rdy0, rdy1, cw0, cw1, ov0, ov1, pe0, pe1;
  logic [15:0] dout0, dout1;

  int          checks = 0;
  int          errors = 0;

  logic [7:0]  sb[$];
  logic        sl[$];
  logic [16:0] mq[$];
  logic [16:0] eq0[$];
  logic [16:0] eq1[$];
  int          merr;
  int          perr_cnt[2];
  int          exp_err[2];
  logic        held[2];
  logic [16:0] held_item[2];

  always #5 clock = ~clock;

  stream_unpacker dut16 (
    .clock            (clock),
    .reset            (reset),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid && !sel),
    .byte_last        (byte_last),
    .byte_ready       (rdy0),
    .data_out         (dout0),
    .control_word_out (cw0),
    .out_data_valid   (ov0),
    .decompressor_busy(busy),
    .protocol_error   (pe0)
  );

  stream_unpacker #(.ITEMS_PER_GROUP(4)) dut4 (
    .clock            (clock),
    .reset            (reset),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid && sel),
    .byte_last        (byte_last),
    .byte_ready       (rdy1),
    .data_out         (dout1),
    .control_word_out (cw1),
    .out_data_valid   (ov1),
    .decompressor_busy(busy),
    .protocol_error   (pe1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Busy pattern: 0 = never busy, 1 = random stalls, 2 = driven by the test itself.
  always @(posedge clock) begin
    #1;
    if (busy_mode == 0) busy = 1'b0;
    else if (busy_mode == 1) busy = ($urandom_range(0, 2) == 0);
  end

  always @(negedge clock) begin
    if (reset) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic        v, r, pe;
        logic [16:0] item, exp;
        v    = d ? ov1 : ov0;
        r    = d ? rdy1 : rdy0;
        pe   = d ? pe1 : pe0;
        item = d ? {cw1, dout1} : {cw0, dout0};
        chk(d ? "ready_vs_valid_4" : "ready_vs_valid_16", 32'(r), 32'(!v));
        if (held[d]) begin
          chk("hold_valid", 32'(v), 32'd1);
          chk("hold_item", 32'(item), 32'(held_item[d]));
        end
        if (pe) perr_cnt[d]++;
        if (v && !busy) begin
          if ((d ? eq1.size() : eq0.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_item dut%0d: got %h expected none", d, item);
          end else begin
            exp = d ? eq1.pop_front() : eq0.pop_front();
            chk(d ? "item_4" : "item_16", 32'(item), 32'(exp));
          end
        end
        held[d]      = v && busy;
        held_item[d] = item;
      end
    end
  end

  // Reference parse of sb/sl: items into mq, malformed endings into merr.
  task automatic model(input int ipg);
    int          pos;
    int          n;
    logic [15:0] ctrl;
    bit          stop;
    pos = 0;
    n   = sb.size();
    mq.delete();
    merr = 0;
    while (pos < n) begin
      if (sl[pos]) begin
        merr++;
        pos++;
        continue;
      end
      if (pos + 1 >= n) break;
      if (sl[pos+1]) begin
        merr++;
        pos += 2;
        continue;
      end
      ctrl = {sb[pos+1], sb[pos]};
      pos += 2;
      stop = 0;
      for (int i = 0; i < ipg && !stop && pos < n; i++) begin
        if (!ctrl[i]) begin
          mq.push_back({1'b0, 8'h00, sb[pos]});
          stop = sl[pos];
          pos++;
        end else if (sl[pos]) begin
          merr++;
          pos++;
          stop = 1;
        end else if (pos + 1 >= n) begin
          pos  = n;
          stop = 1;
        end else begin
          mq.push_back({1'b1, sb[pos], sb[pos+1]});
          stop = sl[pos+1];
          pos += 2;
        end
      end
    end
  endtask

  task automatic add(input logic [7:0] b, input logic l);
    sb.push_back(b);
    sl.push_back(l);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n          = 0;
    byte_in    = b;
    byte_last  = l;
    byte_valid = 1'b1;
    while (!(sel ? rdy1 : rdy0) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sel ? eq1.size() : eq0.size()) != 0 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain", 32'(sel ? eq1.size() : eq0.size()), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic run_stream(input int ipg);
    model(ipg);
    foreach (mq[i]) begin
      if (sel) eq1.push_back(mq[i]);
      else eq0.push_back(mq[i]);
    end
    exp_err[sel] += merr;
    foreach (sb[i]) begin
      if (i % 5 == 3) begin
        @(posedge clock);
        #1;
      end
      send_byte(sb[i], sl[i]);
    end
    wait_drain();
    chk("perr_count", 32'(perr_cnt[sel]), 32'(exp_err[sel]));
    sb.delete();
    sl.delete();
  endtask

  initial begin
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    busy       = 1'b0;
    busy_mode  = 0;
    sel        = 1'b0;
    perr_cnt   = '{0, 0};
    exp_err    = '{0, 0};
    held       = '{1'b0, 1'b0};
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'({ov0, ov1}), 32'd0);
    chk("rst_ready", 32'({rdy0, rdy1}), 32'd3);
    chk("rst_data", 32'({dout0, dout1}), 32'd0);
    chk("rst_cw_perr", 32'({cw0, cw1, pe0, pe1}), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst_ready", 32'({rdy0, ov0}), 32'h2);

    // Literal, copy, then 14 literals.
    add(8'h02, 0); add(8'h00, 0); add(8'h41, 0); add(8'h12, 0); add(8'h34, 0);
    for (int i = 0; i < 14; i++) add(8'(i), 0);
    model(16);
    chk("model_basic_n", 32'(mq.size()), 32'd16);
    chk("model_basic_0", 32'(mq[0]), 32'h00041);
    chk("model_basic_1", 32'(mq[1]), 32'h11234);
    chk("model_basic_15", 32'(mq[15]), 32'h0000D);
    run_stream(16);

    // Mixed group cut short by byte_last on a literal, with random stalls.
    busy_mode = 1;
    add(8'h5A, 0); add(8'h00, 0); add(8'hA0, 0); add(8'hB1, 0); add(8'hB2, 0);
    add(8'hA3, 0); add(8'hC1, 0); add(8'hC2, 0); add(8'hD1, 0); add(8'hD2, 0);
    add(8'hE5, 1);
    model(16);
    chk("model_mixed_n", 32'(mq.size()), 32'd6);
    chk("model_mixed_5", 32'(mq[5]), 32'h000E5);
    run_stream(16);

    // Busy held for 5 cycles from the cycle valid rises.
    busy_mode = 2;
    busy      = 1'b1;
    eq0.push_back(17'h00077);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h77, 1);
    chk("latency_valid", 32'(ov0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("busy_hold", 32'({ov0, rdy0, cw0, dout0}), 32'h40077);
    end
    busy = 1'b0;
    @(posedge clock);
    #1;
    chk("busy_release", 32'({ov0, rdy0}), 32'h1);
    wait_drain();
    busy_mode = 1;

    // Two full all-copy groups back to back.
    for (int g = 0; g < 2; g++) begin
      add(8'hFF, 0); add(8'hFF, 0);
      for (int i = 0; i < 16; i++) begin
        add(8'(g * 16 + i), 0);
        add(~8'(g * 16 + i), 0);
      end
    end
    model(16);
    chk("model_copies_n", 32'(mq.size()), 32'd32);
    chk("model_copies_16", 32'(mq[16]), 32'h110EF);
    run_stream(16);

    // Malformed endings: on a copy first byte, then on a control high byte.
    add(8'h01, 0); add(8'h00, 0); add(8'h9A, 1);
    add(8'h00, 0); add(8'h00, 0); add(8'h55, 1);
    add(8'h00, 0); add(8'hFF, 1);
    add(8'h00, 0); add(8'h00, 0); add(8'h99, 1);
    model(16);
    chk("model_err_n", 32'(merr), 32'd2);
    chk("model_err_items", 32'(mq.size()), 32'd2);
    chk("model_err_0", 32'(mq[0]), 32'h00055);
    run_stream(16);

    // Four-item groups.
    sel = 1'b1;
    add(8'h0A, 0); add(8'h00, 0); add(8'h11, 0); add(8'h22, 0); add(8'h33, 0);
    add(8'h44, 0); add(8'h55, 0); add(8'h66, 0);
    add(8'h01, 0); add(8'h00, 0); add(8'h77, 0); add(8'h88, 1);
    model(4);
    chk("model_g4_n", 32'(mq.size()), 32'd5);
    chk("model_g4_1", 32'(mq[1]), 32'h12233);
    chk("model_g4_2", 32'(mq[2]), 32'h00044);
    chk("model_g4_4", 32'(mq[4]), 32'h17788);
    run_stream(4);

    // Reset while the second byte of a copy is pending.
    sel       = 1'b0;
    busy_mode = 0;
    eq0.push_back(17'h00041);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    wait_drain();
    send_byte(8'h12, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midcopy_rst", 32'({ov0, rdy0, cw0, dout0}), 32'h20000);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midcopy_rst_valid", 32'(ov0), 32'd0);
    add(8'h00, 0); add(8'h00, 0); add(8'h3C, 1);
    run_stream(16);

    chk("leftover_16", 32'(eq0.size()), 32'd0);
    chk("leftover_4", 32'(eq1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
